seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 22 ++
 rtl/seg_scan_driver_hex7seg.sv | 11 +
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, scan FSM state type and glyph table for the seven-segment scan driver.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    typedef enum logic {
        SHOW,
        BLANK
    } scan_state_e;

    // Active-low {g,f,e,d,c,b,a}; entry 15 sits in the most significant slot.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] digitSelect(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// Pure nibble-to-glyph decoder, active-low segments {g..a}.
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with dead-time blanking and frame-aligned data update.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits 7..1.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic        clks,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] din,
    input  logic [7:0]  dp_in,
    output logic [7:0]  outs,
    output logic [7:0]  segs,
    output logic        pending,
    output logic        frame_start
);

    localparam int MAX_COUNT = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

    scan_state_e      state_q;
    logic [2:0]       index_q;
    logic [CNT_W-1:0] prescaler_q;
    logic [7:0]       outs_q;
    logic [7:0]       segs_q;
    logic             frameStart_q;

    logic [31:0] display_q, display_d;
    logic [7:0]  displayDp_q, displayDp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  shadowDp_q, shadowDp_d;
    logic        pending_q, pending_d;

    logic [3:0] nibble;
    logic [6:0] glyph;
    logic       leadingZero;
    logic [7:0] litSegs;
    logic       lastCount;
    logic       advance;
    logic       frameWrap;

    assign nibble = display_q[{index_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are zero.
    assign leadingZero = (index_q != 3'd0) && ((display_q >> {index_q, 2'b00}) == 32'd0);
`else
    assign leadingZero = 1'b0;
`endif

    assign litSegs   = {~displayDp_q[index_q], leadingZero ? 7'h7F : glyph};
    assign lastCount = (state_q == SHOW) ? (prescaler_q == SHOW_LAST) : (prescaler_q == BLANK_LAST);
    assign advance   = en && lastCount && ((state_q == BLANK) || !HAS_DEAD);
    assign frameWrap = advance && (index_q == 3'd7);

    // Outputs are registered from the current state, so they trail the FSM by one clock.
    always_ff @(posedge clks or posedge rst) begin
        if (rst) begin
            state_q      <= SHOW;
            index_q      <= 3'd0;
            prescaler_q  <= '0;
            outs_q       <= DIGIT_OFF;
            segs_q       <= DIGIT_OFF;
            frameStart_q <= 1'b0;
        end else if (en) begin
            if (state_q == SHOW) begin
                outs_q <= digitSelect(index_q);
                segs_q <= litSegs;
            end else begin
                outs_q <= DIGIT_OFF;
                segs_q <= DIGIT_OFF;
            end
            frameStart_q <= (state_q == SHOW) && (index_q == 3'd0) && (prescaler_q == '0);
            if (lastCount) begin
                prescaler_q <= '0;
                if ((state_q == SHOW) && HAS_DEAD) begin
                    state_q <= BLANK;
                end else begin
                    state_q <= SHOW;
                    index_q <= index_q + 3'd1;
                end
            end else begin
                prescaler_q <= prescaler_q + 1'b1;
            end
        end else begin
            outs_q       <= DIGIT_OFF;
            segs_q       <= DIGIT_OFF;
            frameStart_q <= 1'b0;
        end
    end

    // Display only changes on the 7->0 wrap; a load on that very cycle bypasses the shadow.
    always_comb begin
        display_d   = display_q;
        displayDp_d = displayDp_q;
        shadow_d    = shadow_q;
        shadowDp_d  = shadowDp_q;
        pending_d   = pending_q;
        if (load && frameWrap) begin
            display_d   = din;
            displayDp_d = dp_in;
            pending_d   = 1'b0;
        end else if (load) begin
            shadow_d   = din;
            shadowDp_d = dp_in;
            pending_d  = 1'b1;
        end else if (frameWrap && pending_q) begin
            display_d   = shadow_q;
            displayDp_d = shadowDp_q;
            pending_d   = 1'b0;
        end
    end

    always_ff @(posedge clks or posedge rst) begin
        if (rst) begin
            display_q   <= '0;
            displayDp_q <= '0;
            shadow_q    <= '0;
            shadowDp_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            display_q   <= display_d;
            displayDp_q <= displayDp_d;
            shadow_q    <= shadow_d;
            shadowDp_q  <= shadowDp_d;
            pending_q   <= pending_d;
        end
    end

    assign outs        = outs_q;
    assign segs        = segs_q;
    assign pending     = pending_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: one instance with dead time, one without, sharing stimulus.
module tb_seg_scan_driver;

    localparam int SD = 4;

    logic        clks = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] din;
    logic [7:0]  dp_in;

    logic [7:0] outsA, segsA, outsB, segsB;
    logic       pendA, fsA, pendB, fsB;

    int checks = 0;
    int errors = 0;

    always #5 clks = ~clks;

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(1)) dutA (
        .clks(clks), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
        .outs(outsA), .segs(segsA), .pending(pendA), .frame_start(fsA)
    );

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(0)) dutB (
        .clks(clks), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
        .outs(outsB), .segs(segsB), .pending(pendB), .frame_start(fsB)
    );

    typedef struct {
        int          digit;
        int          pos;
        logic [31:0] disp;
        logic [7:0]  dispDp;
        logic [31:0] shad;
        logic [7:0]  shadDp;
        logic        pend;
        logic [7:0]  outs;
        logic [7:0]  segs;
        logic        fs;
    } model_t;

    typedef struct packed {
        logic [7:0] outs;
        logic [7:0] segs;
        logic       fs;
        logic       pend;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;

    typedef struct {
        logic        en;
        logic        ld;
        logic [31:0] din;
        logic [7:0]  dp;
        int          cycles;
        logic        expPend;
        logic [7:0]  expOuts;
    } vec_t;

    model_t mA, mB;
    pair_t  expQ[$];

    function automatic model_t modelInit();
        model_t s;
        s.digit = 0; s.pos = 0;
        s.disp = '0; s.dispDp = '0; s.shad = '0; s.shadDp = '0;
        s.pend = 1'b0; s.outs = 8'hFF; s.segs = 8'hFF; s.fs = 1'b0;
        return s;
    endfunction

    function automatic logic [6:0] hexGlyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0; 4'h1: g = 8'hF9; 4'h2: g = 8'hA4; 4'h3: g = 8'hB0;
            4'h4: g = 8'h99; 4'h5: g = 8'h92; 4'h6: g = 8'h82; 4'h7: g = 8'hF8;
            4'h8: g = 8'h80; 4'h9: g = 8'h90; 4'hA: g = 8'h88; 4'hB: g = 8'h83;
            4'hC: g = 8'hC6; 4'hD: g = 8'hA1; 4'hE: g = 8'h86; default: g = 8'h8E;
        endcase
        return g[6:0];
    endfunction

    function automatic logic [6:0] digitGlyph(input logic [31:0] d, input int digit);
        logic allZero;
        allZero = 1'b1;
        for (int k = digit; k < 8; k++) begin
            if (d[4*k +: 4] != 4'h0) allZero = 1'b0;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (digit != 0 && allZero) return 7'h7F;
`endif
        return hexGlyph(d[4*digit +: 4]);
    endfunction

    function automatic model_t modelStep(input model_t s, input int dead, input logic e,
                                         input logic ld, input logic [31:0] d, input logic [7:0] dp);
        model_t n;
        logic   wrap;
        n = s;
        wrap = 1'b0;
        if (e) begin
            if (s.pos < SD) begin
                n.outs = ~(8'h01 << s.digit);
                n.segs = {~s.dispDp[s.digit], digitGlyph(s.disp, s.digit)};
            end else begin
                n.outs = 8'hFF;
                n.segs = 8'hFF;
            end
            n.fs = (s.digit == 0) && (s.pos == 0);
            n.pos = s.pos + 1;
            if (n.pos == SD + dead) begin
                n.pos = 0;
                wrap = (s.digit == 7);
                n.digit = (s.digit + 1) % 8;
            end
        end else begin
            n.outs = 8'hFF;
            n.segs = 8'hFF;
            n.fs = 1'b0;
        end
        if (ld && wrap) begin
            n.disp = d; n.dispDp = dp; n.pend = 1'b0;
        end else if (ld) begin
            n.shad = d; n.shadDp = dp; n.pend = 1'b1;
        end else if (wrap && s.pend) begin
            n.disp = s.shad; n.dispDp = s.shadDp; n.pend = 1'b0;
        end
        return n;
    endfunction

    function automatic obs_t obsOf(input model_t s);
        obs_t o;
        o.outs = s.outs; o.segs = s.segs; o.fs = s.fs; o.pend = s.pend;
        return o;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        pair_t p;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
            p = expQ.pop_front();
            checkVal("A outs", outsA, p.a.outs);
            checkVal("A segs", segsA, p.a.segs);
            checkVal("A frame_start", fsA, p.a.fs);
            checkVal("A pending", pendA, p.a.pend);
            checkVal("B outs", outsB, p.b.outs);
            checkVal("B segs", segsB, p.b.segs);
            checkVal("B frame_start", fsB, p.b.fs);
            checkVal("B pending", pendB, p.b.pend);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic ld, input logic [31:0] d, input logic [7:0] dp);
        en = e; load = ld; din = d; dp_in = dp;
        mA = modelStep(mA, 1, e, ld, d, dp);
        mB = modelStep(mB, 0, e, ld, d, dp);
        expQ.push_back({obsOf(mA), obsOf(mB)});
        @(posedge clks);
        @(negedge clks);
        checkOutput();
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, 8'h00);
    endtask

    // Reset is raised between clock edges so the blanking must come from the async path.
    task automatic doAsyncReset();
        @(negedge clks);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkVal("reset A outs", outsA, 8'hFF);
        checkVal("reset A segs", segsA, 8'hFF);
        checkVal("reset A pending", pendA, 1'b0);
        checkVal("reset A frame_start", fsA, 1'b0);
        checkVal("reset B outs", outsB, 8'hFF);
        checkVal("reset B pending", pendB, 1'b0);
        @(negedge clks);
        @(negedge clks);
        rst = 1'b0;
        mA = modelInit();
        mB = modelInit();
        expQ.delete();
    endtask

    function automatic vec_t mkVec(input logic e, input logic ld, input logic [31:0] d, input logic [7:0] dp,
                                   input int cyc, input logic p, input logic [7:0] o);
        vec_t v;
        v.en = e; v.ld = ld; v.din = d; v.dp = dp; v.cycles = cyc; v.expPend = p; v.expOuts = o;
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[21];
        vecs[0]  = mkVec(1, 0, 32'h0,        8'h00, 40, 0, 8'hFF);
        vecs[1]  = mkVec(1, 0, 32'h0,        8'h00, 10, 0, 8'hFF);
        vecs[2]  = mkVec(1, 1, 32'h76543210, 8'h01,  1, 1, 8'hFB);
        vecs[3]  = mkVec(1, 0, 32'h0,        8'h00, 28, 1, 8'h7F);
        vecs[4]  = mkVec(1, 0, 32'h0,        8'h00,  1, 0, 8'hFF);
        vecs[5]  = mkVec(1, 0, 32'h0,        8'h00, 40, 0, 8'hFF);
        vecs[6]  = mkVec(1, 1, 32'h11111111, 8'h00,  1, 1, 8'hFE);
        vecs[7]  = mkVec(1, 0, 32'h0,        8'h00,  5, 1, 8'hFD);
        vecs[8]  = mkVec(1, 1, 32'hFFFFFFFF, 8'h00,  1, 1, 8'hFD);
        vecs[9]  = mkVec(1, 0, 32'h0,        8'h00, 33, 0, 8'hFF);
        vecs[10] = mkVec(1, 0, 32'h0,        8'h00, 39, 0, 8'h7F);
        vecs[11] = mkVec(1, 1, 32'hA5A5A5A5, 8'hFF,  1, 0, 8'hFF);
        vecs[12] = mkVec(1, 0, 32'h0,        8'h00, 40, 0, 8'hFF);
        vecs[13] = mkVec(1, 0, 32'h0,        8'h00, 17, 0, 8'hF7);
        vecs[14] = mkVec(0, 0, 32'h0,        8'h00,  5, 0, 8'hFF);
        vecs[15] = mkVec(0, 1, 32'h00000105, 8'h80,  1, 1, 8'hFF);
        vecs[16] = mkVec(0, 0, 32'h0,        8'h00,  4, 1, 8'hFF);
        vecs[17] = mkVec(1, 0, 32'h0,        8'h00,  2, 1, 8'hF7);
        vecs[18] = mkVec(1, 0, 32'h0,        8'h00,  3, 1, 8'hEF);
        vecs[19] = mkVec(1, 0, 32'h0,        8'h00, 17, 1, 8'h7F);
        vecs[20] = mkVec(1, 0, 32'h0,        8'h00,  1, 0, 8'hFF);

        en = 1'b1; load = 1'b0; din = '0; dp_in = '0; rst = 1'b0;
        mA = modelInit();
        mB = modelInit();
        doAsyncReset();

        for (int i = 0; i < 21; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].en, vecs[i].ld, vecs[i].din, vecs[i].dp);
            end
            checkVal($sformatf("table[%0d] A pending", i), pendA, vecs[i].expPend);
            checkVal($sformatf("table[%0d] A outs", i), outsA, vecs[i].expOuts);
        end
        $display("[TB] leading-zero frame shown");
        runIdle(40);

        doAsyncReset();
        runIdle(22);
        checkVal("no-dead digit5 outs", outsB, 8'hDF);
        applyStimulus(1'b1, 1'b1, 32'h12345678, 8'hFF);
        checkVal("no-dead pending before reset", pendB, 1'b1);
        doAsyncReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 8'h00);
        checkVal("first after reset A outs", outsA, 8'hFE);
        checkVal("first after reset A segs", segsA, 8'hC0);
        checkVal("first after reset A frame_start", fsA, 1'b1);
        runIdle(4);
        checkVal("no-dead digit1 without gap", outsB, 8'hFD);
        checkVal("dead-time blank A", outsA, 8'hFF);
        runIdle(35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
